// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD host command stage: CRC7 frame serialiser and R1/R7 response capture
module sd_cmd_engine #(
  parameter int RESP_TIMEOUT = 64,
  parameter int POST_CLKS    = 8
) (
  input  logic        SD_CLK,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_wait,
  output logic        SD_CS,
  output logic        SD_DATAIN,
  input  logic        SD_DATAOUT,
  output logic        busy,
  output logic        resp_valid,
  output logic [47:0] resp_data,
  output logic        resp_crc_ok,
  output logic        resp_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE, S_POST} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [46:0] tx_sh_q;
  logic        rw_q;
  logic        cs_q;
  logic        din_q;
  logic        rv_q;
  logic [47:0] rd_q;
  logic        ok_q;
  logic        to_q;

  logic [47:0] tx_frame_d;
  logic [47:0] rx_shift_d;
  logic        rx_crc_ok_d;

  // CRC7, x^7 + x^3 + 1, zero seed, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Outgoing frame built in parallel at accept; incoming word with the current bit appended
  always_comb begin
    tx_frame_d  = {2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
    rx_shift_d  = {rd_q[46:0], SD_DATAOUT};
    rx_crc_ok_d = (rx_shift_d[7:1] == crc7(rx_shift_d[47:8]));
  end

  // Command/response FSM; one shared counter serves send, wait, receive and post phases
  always_ff @(posedge SD_CLK) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_sh_q <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      din_q   <= 1'b1;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      ok_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cs_q  <= 1'b1;
          din_q <= 1'b1;
          if (cmd_valid) begin
            state_q <= S_SEND;
            cnt_q   <= 8'd48;
            cs_q    <= 1'b0;
            din_q   <= tx_frame_d[47];
            tx_sh_q <= tx_frame_d[46:0];
            rw_q    <= resp_wait;
            rd_q    <= '0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
          end
        end
        S_SEND: begin
          if (cnt_q == 8'd1) begin
            din_q   <= 1'b1;
            cnt_q   <= rw_q ? 8'd0 : 8'(POST_CLKS);
            state_q <= rw_q ? S_WAIT : S_POST;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
            din_q   <= tx_sh_q[46];
            tx_sh_q <= {tx_sh_q[45:0], 1'b1};
          end
        end
        S_WAIT: begin
          // A start bit on the final allowed sample wins over the timeout
          if (!SD_DATAOUT) begin
            rd_q    <= rx_shift_d;
            cnt_q   <= 8'd47;
            state_q <= S_RECV;
          end else if (cnt_q == 8'(RESP_TIMEOUT - 1)) begin
            to_q    <= 1'b1;
            rd_q    <= '1;
            ok_q    <= 1'b0;
            rv_q    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RECV: begin
          rd_q <= rx_shift_d;
          if (cnt_q == 8'd1) begin
            ok_q    <= rx_crc_ok_d;
            rv_q    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: begin
          cnt_q   <= 8'(POST_CLKS);
          state_q <= S_POST;
        end
        S_POST: begin
          if (cnt_q == 8'd1) begin
            cs_q    <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign SD_CS        = cs_q;
  assign SD_DATAIN    = din_q;
  assign resp_valid   = rv_q;
  assign resp_data    = rd_q;
  assign resp_crc_ok  = ok_q;
  assign resp_timeout = to_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - scoreboard bench for sd_cmd_engine
module tb_sd_cmd_engine;

  localparam int T = 64;
  localparam int P = 8;

  logic        SD_CLK;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_wait;
  logic        SD_CS;
  logic        SD_DATAIN;
  logic        SD_DATAOUT;
  logic        busy;
  logic        resp_valid;
  logic [47:0] resp_data;
  logic        resp_crc_ok;
  logic        resp_timeout;

  sd_cmd_engine #(.RESP_TIMEOUT(T), .POST_CLKS(P)) dut (
    .SD_CLK(SD_CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_wait(resp_wait),
    .SD_CS(SD_CS), .SD_DATAIN(SD_DATAIN), .SD_DATAOUT(SD_DATAOUT), .busy(busy),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_crc_ok(resp_crc_ok),
    .resp_timeout(resp_timeout)
  );

  typedef struct packed {
    logic [47:0] d;
    logic        ok;
    logic        to;
  } resp_t;

  logic [47:0] fq[$];
  resp_t       rq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  initial SD_CLK = 1'b0;
  always #5 SD_CLK = ~SD_CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_tb(input logic [39:0] d);
    logic [6:0] c;
    logic       m;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      m = c[6] ^ d[i];
      c = {c[5:3], c[2] ^ m, c[1:0], m};
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_resp(input logic [39:0] d);
    return {d, crc7_tb(d), 1'b1};
  endfunction

  task automatic tick();
    @(posedge SD_CLK);
    #2;
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rw,
                          input logic [47:0] exp_frame, input bit keep);
    logic r;
    int   n;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_wait = rw;
    cmd_valid = 1'b1;
    fq.push_back(exp_frame);
    n = 0;
    do begin
      r = cmd_ready;
      tick();
      n++;
    end while (!r && n < 500);
    if (!r) check("accept_bound", 64'd0, 64'd1);
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      resp_wait = 1'($urandom);
    end
  endtask

  task automatic card_reply(input int gap, input logic [47:0] r);
    for (int i = 0; i < 48; i++) tick();
    SD_DATAOUT = 1'b1;
    for (int i = 0; i < gap; i++) tick();
    for (int i = 47; i >= 0; i--) begin
      SD_DATAOUT = r[i];
      tick();
    end
    SD_DATAOUT = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!cmd_ready && n < 400) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("idle_bound", 64'd0, 64'd1);
  endtask

  // Frame monitor: collects the 48 bits following each accept and compares with the queue head
  always begin : mon_frame
    logic [47:0] got;
    logic [47:0] exp;
    logic        cs_bad;
    bit          ab;
    @(negedge SD_CLK);
    if (rst_n && cmd_valid && cmd_ready) begin
      got    = '0;
      cs_bad = 1'b0;
      ab     = 1'b0;
      for (int i = 0; i < 48; i++) begin
        @(negedge SD_CLK);
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        got    = {got[46:0], SD_DATAIN};
        cs_bad = cs_bad | SD_CS;
      end
      if (fq.size() == 0) begin
        check("frame_unexpected", 64'd1, 64'd0);
      end else begin
        exp = fq.pop_front();
        if (!ab) begin
          check("frame", 64'(got), 64'(exp));
          check("frame_cs_low", 64'(cs_bad), 64'd0);
        end
      end
    end
  end

  // Response monitor: every resp_valid pulse consumes one expected result
  logic rv_prev = 1'b0;
  always @(negedge SD_CLK) begin : mon_resp
    resp_t e;
    if (resp_valid) begin
      check("resp_single_pulse", 64'(rv_prev), 64'd0);
      if (rq.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = rq.pop_front();
        check("resp_data", 64'(resp_data), 64'(e.d));
        check("resp_crc_ok", 64'(resp_crc_ok), 64'(e.ok));
        check("resp_timeout", 64'(resp_timeout), 64'(e.to));
      end
    end
    rv_prev <= resp_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [47:0] r;
    int          n;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_index  = '0;
    cmd_arg    = '0;
    resp_wait  = 1'b0;
    SD_DATAOUT = 1'b1;
    repeat (3) tick();
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cs", 64'(SD_CS), 64'd1);
    check("rst_din", 64'(SD_DATAIN), 64'd1);
    check("rst_rv", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_data), 64'd0);
    check("rst_flags", 64'({resp_crc_ok, resp_timeout}), 64'd0);
    rst_n = 1'b1;
    tick();

    // CMD0, no response: CS low for 48+POST_CLKS cycles
    send_cmd(6'd0, 32'd0, 1'b0, 48'h40_0000_0000_95, 1'b0);
    repeat (55) tick();
    check("cmd0_cs_last", 64'({SD_CS, busy}), 64'b01);
    tick();
    check("cmd0_cs_end", 64'({SD_CS, cmd_ready}), 64'b11);

    // CMD8 with a good R7 after a 5-cycle gap
    send_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 1'b0);
    r = mk_resp(40'h08_0000_01AA);
    rq.push_back('{d: r, ok: 1'b1, to: 1'b0});
    card_reply(5, r);
    wait_idle(n);

    // CMD55 / ACMD41 with corrupted CRC bits; ACMD41 reply starts on the first wait cycle
    send_cmd(6'd55, 32'd0, 1'b1, 48'h77_0000_0000_65, 1'b0);
    r = mk_resp(40'h37_0000_0120) ^ 48'h2;
    rq.push_back('{d: r, ok: 1'b0, to: 1'b0});
    card_reply(2, r);
    wait_idle(n);
    send_cmd(6'd41, 32'h4000_0000, 1'b1, 48'h69_4000_0000_77, 1'b0);
    r = mk_resp(40'h3F_00FF_8000) ^ 48'h10;
    rq.push_back('{d: r, ok: 1'b0, to: 1'b0});
    card_reply(0, r);
    wait_idle(n);
    check("min_busy_resp", 64'(96 + n), 64'd105);

    // Timeout: resp_valid exactly T+1 cycles after the last SEND bit
    send_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 1'b0);
    rq.push_back('{d: '1, ok: 1'b0, to: 1'b1});
    repeat (47 + T) tick();
    check("to_rv_early", 64'(resp_valid), 64'd0);
    tick();
    check("to_rv_on_time", 64'(resp_valid), 64'd1);
    wait_idle(n);
    check("to_hold", 64'({resp_timeout, resp_crc_ok}), 64'b10);
    check("to_hold_data", 64'(resp_data), 64'hFFFF_FFFF_FFFF);

    // No-response command clears the flags
    send_cmd(6'd0, 32'd0, 1'b0, 48'h40_0000_0000_95, 1'b0);
    wait_idle(n);
    check("noresp_flags", 64'({resp_timeout, resp_crc_ok}), 64'd0);

    // Start bit on the final timeout sample is a normal capture
    send_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 1'b0);
    r = mk_resp(40'h08_0000_01AA);
    rq.push_back('{d: r, ok: 1'b1, to: 1'b0});
    card_reply(T - 1, r);
    wait_idle(n);

    // cmd_valid held: second command accepted on the first IDLE cycle
    send_cmd(6'd0, 32'd0, 1'b0, 48'h40_0000_0000_95, 1'b1);
    cmd_index = 6'd55;
    cmd_arg   = 32'd0;
    resp_wait = 1'b0;
    fq.push_back(48'h77_0000_0000_65);
    repeat (55) tick();
    check("hold_not_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("hold_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("hold_accepted", 64'({busy, SD_CS}), 64'b10);
    wait_idle(n);

    // Reset in the middle of SEND
    send_cmd(6'd55, 32'd0, 1'b0, 48'h77_0000_0000_65, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out", 64'({SD_DATAIN, SD_CS, cmd_ready, resp_valid}), 64'b1110);
    send_cmd(6'd0, 32'd0, 1'b0, 48'h40_0000_0000_95, 1'b0);
    wait_idle(n);

    repeat (4) tick();
    check("frames_left", 64'(fq.size()), 64'd0);
    check("resps_left", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Host-side SD command stage; sits directly upstream of the card on the CMD line.
- Accepts a command index and argument from the init/control FSM (sd_initial) over a valid/ready handshake.
- Serialises a 48-bit SD command frame with a computed CRC7, then captures the card's 48-bit response (R1/R7 format) or flags a timeout.
- Reports the captured response, a CRC-check result and a timeout flag back to the controller.

Parameters:
- RESP_TIMEOUT, 64: max SD_CLK cycles in WAIT_RESP without a start bit before timeout; range 1..255.
- POST_CLKS, 8: idle clocks (SD_DATAIN=1, SD_CS low) after each transaction.

Ports:
- SD_CLK input 1: single clock; all logic on posedge.
- rst_n input 1: synchronous active-low reset.
- cmd_valid input 1: command request.
- cmd_ready output 1: high only in IDLE.
- cmd_index input 6: command index.
- cmd_arg input 32: command argument.
- resp_wait input 1: 1 = expect a 48-bit response; sampled with the command.
- SD_CS output 1: card select, active low.
- SD_DATAIN output 1: serial command bit to the card.
- SD_DATAOUT input 1: serial response bit from the card.
- busy output 1: high in any state other than IDLE.
- resp_valid output 1: one-cycle done pulse.
- resp_data output 48: captured response frame, MSB = first bit received.
- resp_crc_ok output 1: received CRC7 matches the computed value.
- resp_timeout output 1: no start bit within RESP_TIMEOUT.

Behaviour:
- Reset (rst_n low at posedge), applied mid-operation too:
  - State goes to IDLE.
  - SD_DATAIN=1, SD_CS=1, resp_valid=0, resp_data=0, resp_crc_ok=0, resp_timeout=0.
  - Counters cleared; any transaction in progress is aborted silently, with no resp_valid.
- Handshake:
  - A transfer occurs when cmd_valid and cmd_ready are both high at a posedge.
  - cmd_index, cmd_arg and resp_wait are latched at that edge; later changes are ignored.
  - cmd_valid is ignored while busy.
- Frame (48 bits, MSB first): bit47=0, bit46=1, [45:40]=cmd_index, [39:8]=cmd_arg, [7:1]=CRC7, bit0=1.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over bits [47:8]. Either a parallel computation at accept or serial during shift is allowed; the result must be identical.
- States:
  - IDLE: SD_CS=1, SD_DATAIN=1. On accept -> SEND, load tx_cnt=48, SD_CS=0.
  - SEND: SD_DATAIN=frame[tx_cnt-1]. The first bit (bit47) is driven the cycle after accept. Exactly 48 cycles. When tx_cnt reaches 0 -> WAIT_RESP if resp_wait, else POST. Clear resp flags at entry.
  - WAIT_RESP: SD_DATAIN=1; sample SD_DATAOUT each posedge.
    - First sampled 0 becomes resp bit47 -> RECV, rx_cnt=47.
    - RESP_TIMEOUT cycles elapse without a 0 -> set resp_timeout=1, resp_data=48'hFFFF_FFFF_FFFF, resp_crc_ok=0 -> DONE.
    - A 0 sampled in the same cycle the count expires counts as a start bit, not a timeout.
  - RECV: shift SD_DATAOUT into resp_data LSB each cycle for 47 cycles -> DONE. resp_crc_ok = (resp_data[7:1] == CRC7 of resp_data[47:8]).
  - DONE: resp_valid=1 for exactly one cycle -> POST.
  - POST: SD_DATAIN=1, SD_CS=0 for POST_CLKS cycles -> IDLE with SD_CS=1.
- Timing and flags:
  - With resp_wait=0 there is no DONE and no resp_valid; the flags stay cleared.
  - Minimum busy time: 48+POST_CLKS cycles (no response); 48+1+47+1+POST_CLKS cycles with the response start bit on the first WAIT cycle.
  - resp_data, resp_crc_ok and resp_timeout hold until the next SEND entry.

Test Plan:
- CMD0, arg 0, resp_wait=0 -> SD_DATAIN shows 48'h40_0000_0000_95 over 48 cycles starting the cycle after accept; SD_CS low for 48+8 cycles; no resp_valid.
- CMD8, arg 32'h1AA -> frame 48'h48_0000_01AA_87. Card returns 48'h08_0000_01AA plus its CRC7 and end bit after a 5-cycle gap -> resp_valid pulse once, resp_data equals the sent frame, resp_crc_ok=1.
- CMD55 arg 0 -> frame 48'h77_0000_0000_65. ACMD41 arg 32'h4000_0000 -> frame 48'h69_4000_0000_77. Responses with a corrupted CRC bit -> resp_crc_ok=0, resp_timeout=0.
- resp_wait=1, SD_DATAOUT held 1 -> resp_valid exactly RESP_TIMEOUT+1 cycles after the last SEND bit; resp_timeout=1, resp_data=all ones. Boundary check: a start bit on the last timeout cycle -> normal capture instead.
- cmd_valid held high throughout busy -> second command accepted only on the first cycle back in IDLE; no frame overlap.
- rst_n low for 1 cycle at SEND bit 20 -> SD_DATAIN=1, SD_CS=1, cmd_ready=1 next cycle; no resp_valid; a following CMD0 is sent correctly.
